driver_mon_mc: RTL and testbench

DRIVER_MON_MC -- requirements
Module: driver_mon_mc

---
 rtl/driver_mon_pkg.sv | 16 +
 rtl/driver_mon_ch.sv | 84 ++++++++
 rtl/driver_mon_mc.sv | 172 +++++++++++++++++
 tb/tb_driver_mon_mc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/driver_mon_pkg.sv
// Shared constants for the FIFO occupancy monitor: FSM encoding and
// register byte offsets.
package driver_mon_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [31:0] OFF_CTRL   = 32'h000;
    localparam logic [31:0] OFF_STATUS = 32'h004;
    localparam logic [31:0] OFF_CYCLE  = 32'h008;
    localparam logic [31:0] OFF_OCC    = 32'h010;
    localparam logic [31:0] OFF_THRESH = 32'h100;
    localparam logic [31:0] OFF_BIN    = 32'h400;

endpackage

// File: rtl/driver_mon_ch.sv
// One monitored channel: occupancy tracking with sticky under/overrun
// flags and an occupancy histogram that counts while the run is active.
module driver_mon_ch
    import driver_mon_pkg::*;
#(
    parameter int OCC_W     = 16,
    parameter int BIN_RANGE = 8,
    parameter int NUM_BINS  = 16,
    parameter int CNT_SIZE  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr,
    input  logic                        rd,
    input  logic                        active,
    input  logic                        bins_clr,
    input  logic                        under_clr,
    input  logic                        over_clr,
    input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
    output logic [OCC_W-1:0]            occ,
    output logic                        underrun,
    output logic                        overrun,
    output logic [CNT_SIZE-1:0]         bin_rdata
);
    localparam int BIN_W = $clog2(NUM_BINS);
    localparam int SHIFT = $clog2(BIN_RANGE);

    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                under_q, under_d;
    logic                over_q, over_d;
    logic [CNT_SIZE-1:0] bins_q [NUM_BINS];
    logic [CNT_SIZE-1:0] bins_d [NUM_BINS];
    logic [OCC_W-1:0]    occ_div;
    logic [BIN_W-1:0]    bin_idx;

    always_comb begin
        occ_d   = occ_q;
        under_d = under_q & ~under_clr;
        over_d  = over_q & ~over_clr;
        if (wr && !rd) begin
            if (&occ_q) over_d = 1'b1;
            else occ_d = occ_q + 1'b1;
        end else if (rd && !wr) begin
            if (occ_q == '0) under_d = 1'b1;
            else occ_d = occ_q - 1'b1;
        end
    end

    // Bin selection uses the occupancy before this cycle's push/pop.
    always_comb begin
        occ_div = occ_q >> SHIFT;
        if (occ_div >= OCC_W'(NUM_BINS - 1)) bin_idx = BIN_W'(NUM_BINS - 1);
        else bin_idx = occ_div[BIN_W-1:0];
    end

    always_comb begin
        for (int b = 0; b < NUM_BINS; b++) begin
            bins_d[b] = bins_q[b];
            if (bins_clr) bins_d[b] = '0;
            else if (active && bin_idx == BIN_W'(b) && !(&bins_q[b]))
                bins_d[b] = bins_q[b] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q   <= '0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= '0;
        end else begin
            occ_q   <= occ_d;
            under_q <= under_d;
            over_q  <= over_d;
            for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= bins_d[b];
        end
    end

    assign occ       = occ_q;
    assign underrun  = under_q;
    assign overrun   = over_q;
    assign bin_rdata = bins_q[rd_bin];

endmodule

// File: rtl/driver_mon_mc.sv
// Multi-channel FIFO occupancy monitor with run FSM and register slave.
// Optional per-channel threshold IRQ enabled by DRIVER_MON_THRESH_IRQ_EN.
module driver_mon_mc
    import driver_mon_pkg::*;
#(
    parameter int          NUM_CH        = 4,
    parameter int          OCC_W         = 16,
    parameter int          BIN_RANGE     = 8,
    parameter int          NUM_BINS      = 16,
    parameter int          CNT_SIZE      = 16,
    parameter logic [31:0] MAX_CYCLE_CNT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       slave_addr,
    input  logic              slave_rd,
    input  logic              slave_wr,
    input  logic [31:0]       slave_data_in,
    output logic [31:0]       slave_data_out,
    input  logic [NUM_CH-1:0] ch_fifo_wr,
    input  logic [NUM_CH-1:0] ch_fifo_rd,
    input  logic              end_program,
    output logic              active_program,
    output logic              run_program,
    output logic              mon_done,
    output logic              mon_irq
);
    localparam int BIN_W = $clog2(NUM_BINS);

    logic [1:0]          state_q, state_d;
    logic [31:0]         cycle_q, cycle_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic [31:0]         rdout_q, rdout_d;
    logic [31:0]         addr_w, rdata, bin_word;
    logic                cmd_start, cmd_stop, cmd_clear, stat_wr;
    logic                enter_active, bin_hit;
    logic [NUM_CH-1:0]   under, over;
    logic [OCC_W-1:0]    occ [NUM_CH];
    logic [CNT_SIZE-1:0] bin_rdata [NUM_CH];
    logic                unused_data;

    assign addr_w      = slave_addr & ~32'h3;
    assign cmd_start   = slave_wr && addr_w == OFF_CTRL && slave_data_in[0];
    assign cmd_stop    = slave_wr && addr_w == OFF_CTRL && slave_data_in[1];
    assign cmd_clear   = slave_wr && addr_w == OFF_CTRL && slave_data_in[2];
    assign stat_wr     = slave_wr && addr_w == OFF_STATUS;
    assign bin_word    = (addr_w - OFF_BIN) >> 2;
    assign bin_hit     = addr_w >= OFF_BIN && bin_word < 32'(NUM_CH * NUM_BINS);
    assign unused_data = ^slave_data_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (cmd_start && !cmd_stop && !cmd_clear) state_d = ST_ACTIVE;
            ST_ACTIVE:
                if (end_program || cmd_stop || cycle_q == MAX_CYCLE_CNT - 32'd1)
                    state_d = ST_DONE;
            ST_DONE:
                if (cmd_clear) state_d = ST_IDLE;
                else if (cmd_start && !cmd_stop) state_d = ST_ACTIVE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_active = state_d == ST_ACTIVE && state_q != ST_ACTIVE;

    always_comb begin
        cycle_d = cycle_q;
        if (enter_active) cycle_d = '0;
        else if (state_q == ST_ACTIVE) cycle_d = cycle_q + 32'd1;
        run_d  = enter_active;
        done_d = state_q == ST_ACTIVE && state_d == ST_DONE;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        driver_mon_ch #(
            .OCC_W     (OCC_W),
            .BIN_RANGE (BIN_RANGE),
            .NUM_BINS  (NUM_BINS),
            .CNT_SIZE  (CNT_SIZE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr        (ch_fifo_wr[c]),
            .rd        (ch_fifo_rd[c]),
            .active    (state_q == ST_ACTIVE),
            .bins_clr  (enter_active),
            .under_clr (stat_wr && slave_data_in[8+c]),
            .over_clr  (stat_wr && slave_data_in[16+c]),
            .rd_bin    (bin_word[BIN_W-1:0]),
            .occ       (occ[c]),
            .underrun  (under[c]),
            .overrun   (over[c]),
            .bin_rdata (bin_rdata[c])
        );
    end

`ifdef DRIVER_MON_THRESH_IRQ_EN
    logic [15:0] thresh_q [NUM_CH];
    logic [15:0] thresh_d [NUM_CH];
    logic        irq_q, irq_d;

    always_comb begin
        irq_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            thresh_d[c] = thresh_q[c];
            if (slave_wr && addr_w == OFF_THRESH + 32'(4 * c))
                thresh_d[c] = slave_data_in[15:0];
            if (32'(occ[c]) > 32'(thresh_q[c])) irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) thresh_q[c] <= '0;
        end else begin
            irq_q <= irq_d;
            for (int c = 0; c < NUM_CH; c++) thresh_q[c] <= thresh_d[c];
        end
    end

    assign mon_irq = irq_q;
`else
    assign mon_irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (addr_w == OFF_CYCLE) rdata = cycle_q;
        if (addr_w == OFF_STATUS) begin
            rdata[1:0] = state_q;
            for (int c = 0; c < NUM_CH; c++) begin
                rdata[8+c]  = under[c];
                rdata[16+c] = over[c];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_w == OFF_OCC + 32'(4 * c)) rdata = 32'(occ[c]);
            if (bin_hit && (bin_word >> BIN_W) == 32'(c))
                rdata = 32'(bin_rdata[c]);
`ifdef DRIVER_MON_THRESH_IRQ_EN
            if (addr_w == OFF_THRESH + 32'(4 * c)) rdata = 32'(thresh_q[c]);
`endif
        end
        rdout_d = slave_rd ? rdata : rdout_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            rdout_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            run_q   <= run_d;
            done_q  <= done_d;
            rdout_q <= rdout_d;
        end
    end

    assign slave_data_out = rdout_q;
    assign active_program = state_q == ST_ACTIVE;
    assign run_program    = run_q;
    assign mon_done       = done_q;

endmodule

// File: tb/tb_driver_mon_mc.sv
// Directed self-checking bench for driver_mon_mc; threshold IRQ steps
// follow DRIVER_MON_THRESH_IRQ_EN.
module tb_driver_mon_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] slave_addr = '0;
    logic        slave_rd = 1'b0;
    logic        slave_wr = 1'b0;
    logic [31:0] slave_data_in = '0;
    logic [31:0] slave_data_out;
    logic [3:0]  ch_fifo_wr = '0;
    logic [3:0]  ch_fifo_rd = '0;
    logic        end_program = 1'b0;
    logic        active_program, run_program, mon_done, mon_irq;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_snap;
    logic [31:0] rv;

    driver_mon_mc dut (
        .clk            (clk),
        .reset          (reset),
        .slave_addr     (slave_addr),
        .slave_rd       (slave_rd),
        .slave_wr       (slave_wr),
        .slave_data_in  (slave_data_in),
        .slave_data_out (slave_data_out),
        .ch_fifo_wr     (ch_fifo_wr),
        .ch_fifo_rd     (ch_fifo_rd),
        .end_program    (end_program),
        .active_program (active_program),
        .run_program    (run_program),
        .mon_done       (mon_done),
        .mon_irq        (mon_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus/FIFO tasks start and end on a falling edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        slave_addr = a; slave_data_in = d; slave_wr = 1'b1;
        @(negedge clk);
        slave_wr = 1'b0; slave_data_in = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        slave_addr = a; slave_rd = 1'b1;
        @(negedge clk);
        slave_rd = 1'b0;
        d = slave_data_out;
    endtask

    task automatic push(input logic [3:0] w, input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            ch_fifo_wr = w; ch_fifo_rd = r;
            @(negedge clk);
        end
        ch_fifo_wr = '0; ch_fifo_rd = '0;
    endtask

    initial begin
        #1;
        check("rst_active", {31'd0, active_program}, 32'd0);
        check("rst_done", {31'd0, mon_done}, 32'd0);
        check("rst_run", {31'd0, run_program}, 32'd0);
        check("rst_irq", {31'd0, mon_irq}, 32'd0);
        check("rst_dout", slave_data_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_rd(32'h004, rv); check("rst_status", rv, 32'd0);
        bus_rd(32'h008, rv); check("rst_cycle", rv, 32'd0);

        // 10 active cycles with no traffic
        bus_wr(32'h000, 32'd1);
        check("run_pulse", {31'd0, run_program}, 32'd1);
        check("active_hi", {31'd0, active_program}, 32'd1);
        repeat (9) @(negedge clk);
        bus_wr(32'h000, 32'd2);
        @(negedge clk);
        check("t1_done_cnt", done_cnt, 32'd1);
        bus_rd(32'h008, rv); check("t1_cycle", rv, 32'd10);
        bus_rd(32'h400, rv); check("t1_ch0_bin0", rv, 32'd10);
        bus_rd(32'h440, rv); check("t1_ch1_bin0", rv, 32'd10);
        bus_rd(32'h480, rv); check("t1_ch2_bin0", rv, 32'd10);
        bus_rd(32'h4C0, rv); check("t1_ch3_bin0", rv, 32'd10);
        bus_rd(32'h004, rv); check("t1_status", rv, 32'd2);

        // ch1 at occupancy 20 lands in bin 2
        push(4'b0010, 4'b0000, 20);
        bus_rd(32'h014, rv); check("t2_occ1", rv, 32'd20);
        bus_wr(32'h000, 32'd1);
        repeat (4) @(negedge clk);
        bus_wr(32'h000, 32'd2);
        bus_rd(32'h448, rv); check("t2_ch1_bin2", rv, 32'd5);
        bus_rd(32'h440, rv); check("t2_ch1_bin0", rv, 32'd0);
        bus_rd(32'h008, rv); check("t2_cycle", rv, 32'd5);
        check("t2_done_cnt", done_cnt, 32'd2);

        // underrun on ch0, then write-one-to-clear
        push(4'b0000, 4'b0001, 1);
        bus_rd(32'h010, rv); check("t3_occ0", rv, 32'd0);
        bus_rd(32'h004, rv); check("t3_status_ur", rv, 32'h102);
        bus_wr(32'h004, 32'h100);
        bus_rd(32'h004, rv); check("t3_status_w1c", rv, 32'h002);

        // simultaneous push and pop
        push(4'b0100, 4'b0000, 3);
        push(4'b0100, 4'b0100, 1);
        bus_rd(32'h018, rv); check("t4_occ2", rv, 32'd3);

        // occupancy 200 clamps to last bin; stop + end_program together
        push(4'b0001, 4'b0000, 200);
        bus_rd(32'h010, rv); check("t5_occ0", rv, 32'd200);
        bus_wr(32'h000, 32'd1);
        repeat (2) @(negedge clk);
        end_program = 1'b1;
        bus_wr(32'h000, 32'd2);
        end_program = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_done_cnt", done_cnt, 32'd3);
        bus_rd(32'h43C, rv); check("t5_ch0_bin15", rv, 32'd3);
        bus_rd(32'h480, rv); check("t5_ch2_bin0", rv, 32'd3);
        bus_rd(32'h448, rv); check("t5_ch1_bin2", rv, 32'd3);
        bus_rd(32'h008, rv); check("t5_cycle", rv, 32'd3);
        bus_rd(32'h7FC, rv); check("t5_unmapped", rv, 32'd0);

        bus_wr(32'h000, 32'd4);
        bus_rd(32'h004, rv); check("clr_status", rv, 32'd0);
        bus_wr(32'h000, 32'd7);
        bus_rd(32'h004, rv); check("prio_idle", rv, 32'd0);
        bus_rd(32'h000, rv); check("ctrl_rd0", rv, 32'd0);

`ifdef DRIVER_MON_THRESH_IRQ_EN
        bus_wr(32'h10C, 32'd4);
        bus_rd(32'h10C, rv); check("thr_rd", rv, 32'd4);
        push(4'b1000, 4'b0000, 5);
        check("irq_lag", {31'd0, mon_irq}, 32'd0);
        @(negedge clk);
        check("irq_hi", {31'd0, mon_irq}, 32'd1);
`else
        bus_wr(32'h10C, 32'd4);
        bus_rd(32'h10C, rv); check("thr_rd0", rv, 32'd0);
        push(4'b1000, 4'b0000, 5);
        @(negedge clk);
        check("irq_tied", {31'd0, mon_irq}, 32'd0);
`endif
        bus_rd(32'h01C, rv); check("occ3", rv, 32'd5);

        // reset in the middle of a run
        bus_wr(32'h000, 32'd1);
        repeat (3) @(negedge clk);
        done_snap = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("mid_active", {31'd0, active_program}, 32'd0);
        check("mid_irq", {31'd0, mon_irq}, 32'd0);
        check("mid_dout", slave_data_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(32'h004, rv); check("mid_status", rv, 32'd0);
        bus_rd(32'h008, rv); check("mid_cycle", rv, 32'd0);
        bus_rd(32'h010, rv); check("mid_occ0", rv, 32'd0);
        bus_rd(32'h01C, rv); check("mid_occ3", rv, 32'd0);
        bus_rd(32'h43C, rv); check("mid_bin", rv, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_no_done", done_cnt, done_snap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
